decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised RV32I decode stage: accepts fetched instructions over a valid/ready handshake, extracts class, register indices and sign-extended immediate, and buffers decoded bundles in a DEPTH-entry FIFO that feeds the next stage. It sits between fetch and issue, adds backpressure and flush support, and replaces the single-register, no-stall decode path.

## Interface
- ADDR_WIDTH, 32, instruction address width; addresses carried as [ADDR_WIDTH-1:2] (4-byte aligned)
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode can accept this cycle
- in_addr  in  ADDR_WIDTH-2  instruction address [ADDR_WIDTH-1:2]
- in_insn  in  32  instruction word
- out_valid  out  1  FIFO head holds a decoded bundle
- out_ready  in  1  consumer takes head this cycle
- out_addr  out  ADDR_WIDTH-2  address of head
- out_insn  out  32  raw instruction of head
- out_class  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 6 SYSTEM, 7 OTHER
- out_rd, out_rs1, out_rs2  out  5 each  insn[11:7], [19:15], [24:20]
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  head is an illegal encoding
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- in_ready = (count < DEPTH); no same-cycle pass-through when full.
- Classification by opcode insn[6:0]: 0110111/0010111/0010011/0110011 -> ALU; 0000011 LOAD; 0100011 STORE; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; 1110011 SYSTEM; anything else OTHER.
- Immediate: I-type (LOAD, OP-IMM, JALR, SYSTEM) {insn[31] x21, insn[30:20]}; S {x21 sign, [30:25],[11:7]}; B {x20 sign,[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {x12 sign,[19:12],[20],[30:21],0}; OP and OTHER -> 0.
- Decode is combinational on input; decoded fields are written into FIFO storage at push. Outputs are driven from the head entry.
- Read/write pointers are log2(DEPTH) bits, wrap naturally; count tracks occupancy (+1 push, -1 pop, unchanged on both).
- Simultaneous push and pop when 0 < count < DEPTH: both occur, count unchanged.
- flush: pointers and count cleared next cycle; same-cycle input and pop ignored; flush wins over all.
- rst: same as flush; out_valid=0, count=0, in_ready=1 after reset. Data outputs undefined (storage not reset) but out_illegal, out_class read from entry 0 are don't-care while out_valid=0.

## Timing
- Latency: instruction pushed in cycle N is visible at head (out_valid=1) in cycle N+1 if FIFO was empty.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- in_ready depends only on registered count (no combinational path from out_ready).
- out_* depend only on registered state.
- Reset or flush asserted mid-stream: cycle after, out_valid=0, count=0, in_ready=1.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: out_illegal set at push if insn[1:0] != 2'b11, or opcode not in {classified set, 0001111}, or BRANCH with funct3 in {010,011}, or JALR with funct3 != 000; entry still enqueued.
- Undefined: out_illegal tied 0; no illegal logic synthesised.

## Test plan
- After rst: out_valid=0, count=0, in_ready=1; push in_addr=0x100, in_insn=0x00A00093 (addi x1,x0,10) -> next cycle out_valid=1, out_class=0, out_rd=1, out_rs1=0, out_imm=0x0000000A, out_addr=0x100.
- Immediates: push 0xFE0008E3 (beq x0,x0,-16) -> class 3, imm 0xFFFFFFF0; 0x0080006F (jal x0,8) -> class 4, imm 8; 0x123450B7 (lui) -> class 0, imm 0x12345000; 0x00112623 (sw x1,12(x2)) -> class 2, imm 12.
- Backpressure: out_ready=0, push DEPTH instructions -> count=DEPTH, in_ready=0; extra in_valid ignored; set out_ready=1 -> pops in push order, no loss or duplication.
- Concurrent push/pop with count=2 for 10 cycles -> count stays 2, order preserved across pointer wrap.
- Flush with count=3 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, flushed input never appears.
- With DECODE_ILLEGAL_CHECK_EN: push 0x00000000 and 0x0000A063 (branch funct3=010) -> out_illegal=1; 0x00008067 (jalr) -> out_illegal=0, class 5. Without macro: out_illegal=0 for all.

Source files
------------

// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// decode_queue_if
// Bundles the fetch-side and issue-side handshakes of decode_queue.
//   flush          : discard everything buffered plus this cycle's input
//   in_valid/ready : fetch handshake, in_addr is the word address [ADDR_WIDTH-1:2]
//   in_insn        : raw 32-bit instruction word
//   out_valid/ready: issue handshake for the FIFO head
//   out_addr/insn  : address and raw word of the head entry
//   out_class      : 0 ALU,1 LOAD,2 STORE,3 BRANCH,4 JAL,5 JALR,6 SYSTEM,7 OTHER
//   out_rd/rs1/rs2 : register index fields of the head entry
//   out_imm        : sign-extended immediate of the head entry
//   out_illegal    : head entry is an illegal encoding
//   count          : occupied FIFO entries
// master = producer/consumer side (fetch + issue), slave = the decode queue.
// -----------------------------------------------------------------------------
interface decode_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [ADDR_WIDTH-3:0]         in_addr;
    logic [31:0]                   in_insn;
    logic                          out_valid;
    logic                          out_ready;
    logic [ADDR_WIDTH-3:0]         out_addr;
    logic [31:0]                   out_insn;
    logic [2:0]                    out_class;
    logic [4:0]                    out_rd;
    logic [4:0]                    out_rs1;
    logic [4:0]                    out_rs2;
    logic [31:0]                   out_imm;
    logic                          out_illegal;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output flush, in_valid, in_addr, in_insn, out_ready,
        input  in_ready, out_valid, out_addr, out_insn, out_class,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_addr, in_insn, out_ready,
        output in_ready, out_valid, out_addr, out_insn, out_class,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
// RV32I decode stage with a DEPTH-entry FIFO between fetch and issue.
// Incoming instructions are decoded combinationally (class, immediate) and the
// decoded bundle is written into the FIFO on push; all out_* signals come from
// the head entry, i.e. from registered state only.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (same effect as flush)
//   bus  : decode_queue_if.slave, fetch and issue handshakes plus flush/count
// Parameters: ADDR_WIDTH (address width, low 2 bits dropped), DEPTH (power of 2, >= 2)
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN -- when defined, illegal
// encodings are flagged at push time; otherwise out_illegal is tied low.
// -----------------------------------------------------------------------------
module decode_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst,
    decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_JALR   = 3'd5;
    localparam logic [2:0] CLS_SYSTEM = 3'd6;
    localparam logic [2:0] CLS_OTHER  = 3'd7;

    typedef struct packed {
        logic [ADDR_WIDTH-3:0] addr;
        logic [31:0]           insn;
        logic [2:0]            cls;
        logic [31:0]           imm;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              push;
    logic              pop;
    logic [2:0]        dec_class;
    logic [31:0]       dec_imm;
    logic [31:0]       insn;
    logic [6:0]        opcode;

    assign insn   = bus.in_insn;
    assign opcode = insn[6:0];

    // in_ready comes from the registered count only, so a full queue never
    // accepts even if the head is being popped in the same cycle.
    assign bus.in_ready  = (count_reg < FULL_CNT);
    assign bus.out_valid = (count_reg != '0);
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    // Combinational decode of the incoming word.
    always_comb begin
        dec_class = CLS_OTHER;
        dec_imm   = 32'd0;
        case (opcode)
            7'b0110111, 7'b0010111: begin   // LUI, AUIPC: U-type
                dec_class = CLS_ALU;
                dec_imm   = {insn[31:12], 12'b0};
            end
            7'b0010011: begin               // OP-IMM: I-type
                dec_class = CLS_ALU;
                dec_imm   = {{21{insn[31]}}, insn[30:20]};
            end
            7'b0110011: dec_class = CLS_ALU; // OP: no immediate
            7'b0000011: begin
                dec_class = CLS_LOAD;
                dec_imm   = {{21{insn[31]}}, insn[30:20]};
            end
            7'b0100011: begin
                dec_class = CLS_STORE;
                dec_imm   = {{21{insn[31]}}, insn[30:25], insn[11:7]};
            end
            7'b1100011: begin
                dec_class = CLS_BRANCH;
                dec_imm   = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_class = CLS_JAL;
                dec_imm   = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_class = CLS_JALR;
                dec_imm   = {{21{insn[31]}}, insn[30:20]};
            end
            7'b1110011: begin
                dec_class = CLS_SYSTEM;
                dec_imm   = {{21{insn[31]}}, insn[30:20]};
            end
            default: begin
                dec_class = CLS_OTHER;
                dec_imm   = 32'd0;
            end
        endcase
    end

    // Pointer and occupancy tracking; flush has priority over everything.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Storage is not reset; outputs are don't-care while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{addr: bus.in_addr, insn: insn,
                                 cls: dec_class, imm: dec_imm};
        end
    end

    assign bus.out_addr  = mem[rd_ptr_reg].addr;
    assign bus.out_insn  = mem[rd_ptr_reg].insn;
    assign bus.out_class = mem[rd_ptr_reg].cls;
    assign bus.out_imm   = mem[rd_ptr_reg].imm;
    assign bus.out_rd    = mem[rd_ptr_reg].insn[11:7];
    assign bus.out_rs1   = mem[rd_ptr_reg].insn[19:15];
    assign bus.out_rs2   = mem[rd_ptr_reg].insn[24:20];
    assign bus.count     = count_reg;

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic       illegal_mem [DEPTH];
    logic       dec_illegal;
    logic       known_opcode;
    logic [2:0] funct3;

    assign funct3 = insn[14:12];

    always_comb begin
        known_opcode = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011,
            7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b1110011, 7'b0001111: known_opcode = 1'b1;
            default:                            known_opcode = 1'b0;
        endcase
    end

    // Branch funct3 010/011 are unassigned; JALR only defines funct3 000.
    assign dec_illegal = (insn[1:0] != 2'b11) || !known_opcode
                      || (opcode == 7'b1100011 && funct3[2:1] == 2'b01)
                      || (opcode == 7'b1100111 && funct3 != 3'b000);

    always_ff @(posedge clk) begin
        if (push) illegal_mem[wr_ptr_reg] <= dec_illegal;
    end

    assign bus.out_illegal = illegal_mem[rd_ptr_reg];
`else
    assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_queue_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    decode_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] insn;
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;   // illegal when the check is enabled
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [29:0] addr, input logic [31:0] word);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_insn  = word;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    int q [$];

    initial begin
        vecs[0]  = '{32'h00A00093, 3'd0, 5'd1,  5'd0, 5'd10, 32'h0000000A, 1'b0}; // addi x1,x0,10
        vecs[1]  = '{32'hFE0008E3, 3'd3, 5'd17, 5'd0, 5'd0,  32'hFFFFFFF0, 1'b0}; // beq -16
        vecs[2]  = '{32'h0080006F, 3'd4, 5'd0,  5'd0, 5'd8,  32'h00000008, 1'b0}; // jal x0,8
        vecs[3]  = '{32'h123450B7, 3'd0, 5'd1,  5'd8, 5'd3,  32'h12345000, 1'b0}; // lui
        vecs[4]  = '{32'h00112623, 3'd2, 5'd12, 5'd2, 5'd1,  32'h0000000C, 1'b0}; // sw x1,12(x2)
        vecs[5]  = '{32'hFFC32283, 3'd1, 5'd5,  5'd6, 5'd28, 32'hFFFFFFFC, 1'b0}; // lw x5,-4(x6)
        vecs[6]  = '{32'h00000073, 3'd6, 5'd0,  5'd0, 5'd0,  32'h00000000, 1'b0}; // ecall
        vecs[7]  = '{32'h002081B3, 3'd0, 5'd3,  5'd1, 5'd2,  32'h00000000, 1'b0}; // add x3,x1,x2
        vecs[8]  = '{32'h0000000F, 3'd7, 5'd0,  5'd0, 5'd0,  32'h00000000, 1'b0}; // fence
        vecs[9]  = '{32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  32'h00000000, 1'b1}; // all zero
        vecs[10] = '{32'h0000A063, 3'd3, 5'd0,  5'd1, 5'd0,  32'h00000000, 1'b1}; // branch f3=010
        vecs[11] = '{32'h00008067, 3'd5, 5'd0,  5'd1, 5'd0,  32'h00000000, 1'b0}; // jalr x0,0(x1)
        vecs[12] = '{32'h00001217, 3'd0, 5'd4,  5'd0, 5'd0,  32'h00001000, 1'b0}; // auipc x4,1

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr = '0;
        bus.in_insn = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Table: push one, check head the next cycle, then pop it.
        for (int i = 0; i < NV; i++) begin
            push_one(30'(32'h100 + i), vecs[i].insn);
            $display("vec %0d insn=%08h class=%0d imm=%08h ill=%0b",
                     i, bus.out_insn, bus.out_class, bus.out_imm, bus.out_illegal);
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'd1);
            chk($sformatf("v%0d_addr", i),  32'(bus.out_addr), 32'h100 + 32'(i));
            chk($sformatf("v%0d_insn", i),  bus.out_insn, vecs[i].insn);
            chk($sformatf("v%0d_class", i), 32'(bus.out_class), 32'(vecs[i].cls));
            chk($sformatf("v%0d_rd", i),    32'(bus.out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i),   32'(bus.out_rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i),   32'(bus.out_rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_imm", i),   bus.out_imm, vecs[i].imm);
            chk($sformatf("v%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].ill & ILL_EN));
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk($sformatf("v%0d_popped", i), 32'(bus.count), 32'd0);
        end

        // Backpressure: fill, then try one more push, then drain in order.
        for (int k = 0; k < DEPTH; k++) begin
            push_one(30'(32'h200 + k), (32'(k) << 20) | 32'h00000093);
            $display("fill %0d count=%0d", k, bus.count);
        end
        chk("full_count",    32'(bus.count),    32'(DEPTH));
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        push_one(30'h2FF, 32'h7FF00093);
        chk("full_ignored_count", 32'(bus.count), 32'(DEPTH));
        bus.out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            $display("drain %0d addr=%0h", k, bus.out_addr);
            chk($sformatf("drain%0d_addr", k), 32'(bus.out_addr), 32'h200 + 32'(k));
            chk($sformatf("drain%0d_imm", k),  bus.out_imm, 32'(k));
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // Concurrent push/pop at count=2 across pointer wrap.
        push_one(30'h300, 32'h00000013);
        push_one(30'h301, 32'h00000013);
        q.push_back(32'h300);
        q.push_back(32'h301);
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("cc%0d_count", j), 32'(bus.count), 32'd2);
            chk($sformatf("cc%0d_addr", j),  32'(bus.out_addr), q[0]);
            $display("concurrent %0d head=%0h", j, bus.out_addr);
            bus.in_valid  = 1'b1;
            bus.in_addr   = 30'(32'h302 + j);
            bus.in_insn   = 32'h00000013;
            bus.out_ready = 1'b1;
            q.push_back(32'h302 + 32'(j));
            void'(q.pop_front());
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("cc_end_count", 32'(bus.count), 32'd2);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("cc_drain%0d_addr", j), 32'(bus.out_addr), q[0]);
            void'(q.pop_front());
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("cc_drain_count", 32'(bus.count), 32'd0);

        // Flush with count=3 and a push/pop attempted in the same cycle.
        for (int k = 0; k < 3; k++) push_one(30'(32'h400 + k), 32'h00000013);
        chk("pre_flush_count", 32'(bus.count), 32'd3);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 30'h3FF;
        bus.in_insn   = 32'h00000013;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        $display("flush count=%0d valid=%0b", bus.count, bus.out_valid);
        chk("flush_count",    32'(bus.count),     32'd0);
        chk("flush_valid",    32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        chk("flush_stays_empty", 32'(bus.out_valid), 32'd0);
        push_one(30'h410, 32'h00000013);
        chk("post_flush_addr",  32'(bus.out_addr), 32'h410);
        chk("post_flush_count", 32'(bus.count), 32'd1);

        // Reset mid-stream.
        push_one(30'h420, 32'h00000013);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("midreset count=%0d valid=%0b", bus.count, bus.out_valid);
        chk("midrst_count",    32'(bus.count),     32'd0);
        chk("midrst_valid",    32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
